jstk_spi_master: RTL and testbench
==================================

// Module: jstk_spi_master
// PURPOSE
//  SPI mode-0 transaction engine for the PmodJSTK. Sits directly under the joystick interface.
//  On each sndRec rising edge (10 Hz) it:
//   - sends the 5-byte command word DIN (RGB LED command);
//   - captures the 5 joystick bytes into DOUT;
//   - DOUT then feeds the X/Y/button decode and the LED stage.
//  Enforces the PmodJSTK SS-setup and inter-byte gaps at the 12 MHz board clock.
// PARAMETERS
//  SCLK_HALF  90   CLK cycles per SCLK half-period (12 MHz/180 = 66.7 kHz; PmodJSTK max 1 MHz)
//  SS_SETUP   180  CLK cycles from SS low to first SCLK rise (15 us)
//  BYTE_GAP   120  CLK cycles of SCLK-low idle between bytes (10 us)
//  NBYTES     5    bytes per transaction; DIN/DOUT width = 8*NBYTES
// PORTS
//  CLK     in   1   12 MHz system clock
//  RST     in   1   asynchronous, active-high reset
//  sndRec  in   1   transaction request; rising edge starts one transaction
//  DIN     in   40  command bytes; DIN[39:32] sent first
//  MISO    in   1   serial data from PmodJSTK
//  SS      out  1   slave select, active low
//  SCLK    out  1   serial clock, idles low
//  MOSI    out  1   serial data to PmodJSTK, MSB first
//  DOUT    out  40  last complete received frame; first byte in [39:32], buttons in [1:0]
//  BUSY    out  1   high from start acceptance until SS returns high
//  DONE    out  1   one-cycle pulse when DOUT updates
// BEHAVIOUR
//  Reset values (asynchronous, immediate):
//   - SS=1, SCLK=0, MOSI=0, DOUT=0, BUSY=0, DONE=0; FSM forced to IDLE.
//   - Reset mid-transaction aborts: SS high in the same instant; partial data is discarded.
//  Start detect:
//   - sndRec is registered once; start = sndRec & ~sndRec_q.
//   - Level-high sndRec does not retrigger.
//   - A start while BUSY is ignored, not queued.
//  FSM states:
//   - IDLE: on start, latch DIN into tx_sr, clear rx_sr, byte_cnt=0, go to SETUP.
//     SS=0 and BUSY=1 from the next cycle.
//   - SETUP: wait SS_SETUP cycles; MOSI=tx_sr[39] throughout; go to SHIFT.
//   - SHIFT: runs 8 bits; each bit is SCLK high for SCLK_HALF cycles, then low for SCLK_HALF cycles.
//     - At SCLK rise: rx_sr <= {rx_sr[38:0], MISO}.
//     - At SCLK fall: tx_sr <= {tx_sr[38:0], 1'b0}, so MOSI is stable a full half-period before the next rise.
//     - After the 8th fall: byte_cnt++. If byte_cnt==NBYTES go to DONE_ST, else go to GAP.
//   - GAP: wait BYTE_GAP cycles with SCLK=0 and SS=0; go to SHIFT.
//   - DONE_ST (1 cycle): DOUT <= rx_sr, DONE=1, SS=1, BUSY=0 on the following cycle; go to IDLE.
//  Frame timing (defaults):
//   - Start-edge cycle to SS fall: 2 CLK (sync register + FSM).
//   - SS low duration = SS_SETUP + NBYTES*16*SCLK_HALF + (NBYTES-1)*BYTE_GAP + 1 = 7861 CLK.
//  Outputs and counters:
//   - DOUT is atomic: it changes only in DONE_ST and holds between frames.
//   - SCLK, SS and MOSI are driven from flops (glitch-free).
//   - Tick counter width is $clog2(max(SCLK_HALF, SS_SETUP, BYTE_GAP)).
//   - Tick counter reloads on each state or half-period change; no wrap-around beyond terminal count.
//   - Bit counter: 3 bits. Byte counter: $clog2(NBYTES+1) bits.
//  Simultaneous events:
//   - Start arriving in the same cycle as DONE_ST is ignored (BUSY still high).
//  MISO is sampled directly; the 66.7 kHz SCLK gives ample setup margin.
// STRUCTURE
//  jstk_defs.vh (shared include): FSM state localparams, NBYTES, the default timing constants, and the command opcode 8'h84.
//  Sub-module spi_byte_shifter: 8-bit tx/rx shift pair with load, shift-on-rise/fall enables and a bit_done flag.
//  The parent FSM sequences bytes and timing.
// TESTING
//  1. Reset idle: RST=1 then release, sndRec=0 -> SS=1, SCLK=0, MOSI=0, DOUT=0, BUSY=0 for 10000 cycles.
//  2. Loopback: DIN=40'h84_FF00_AA_00, slave model echoes the previous MOSI byte. Check:
//     - exactly 40 SCLK rises; MOSI bit order matches DIN MSB first;
//     - DOUT equals the model bytes; DONE pulses once;
//     - SS low for 7861 cycles.
//  3. Timing: measure SS fall to first SCLK rise = 180 cycles; SCLK period = 180 cycles; inter-byte SCLK-low gap = 120+90 cycles.
//  4. Start while busy: second sndRec edge 1000 cycles into a frame -> no restart, one DONE, DOUT from the first frame only.
//  5. Mid-frame reset: assert RST during byte 3. Check:
//     - SS=1 and SCLK=0 asynchronously; DOUT keeps its prior value 0;
//     - after release, the next sndRec runs a clean full frame.
//  6. Button decode: slave returns bytes 10,02,F4,01,03 -> DOUT=40'h1002F40103, DOUT[1:0]=2'b11.
//     The held-high sndRec level for 3 frames' worth of time gives a single transaction.

Source files
------------

// File: rtl/jstk_spi_master_pkg.sv
// rtl/jstk_spi_master_pkg.sv - shared constants and FSM state type for the PmodJSTK SPI engine
// Purpose: frame size, board-clock timing constants and the sequencing FSM states.
// Ports: none (package).
package jstk_spi_master_pkg;

    localparam int NBYTES    = 5;    // bytes per transaction
    localparam int SCLK_HALF = 90;   // CLK cycles per SCLK half-period
    localparam int SS_SETUP  = 180;  // CLK cycles from SS low to first SCLK rise
    localparam int BYTE_GAP  = 120;  // extra SCLK-low idle between bytes

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE_ST
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/jstk_spi_master_shifter.sv
// rtl/jstk_spi_master_shifter.sv - 8-bit SPI tx/rx shift pair with bit counting
// Purpose: holds the byte in flight; shifts rx on SCLK rise, tx on SCLK fall.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   load         load_data into tx, clear rx and the bit count
//   rise_en      sample miso into rx (SCLK rising)
//   fall_en      advance tx (SCLK falling), count the bit
//   miso         serial input
//   mosi         tx MSB, straight from a flop
//   rx_data      received byte
//   bit_done     set after the 8th fall, cleared by load
module jstk_spi_master_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       rise_en,
    input  logic       fall_en,
    input  logic       miso,
    output logic       mosi,
    output logic [7:0] rx_data,
    output logic       bit_done
);

    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            bit_done <= 1'b0;
        end else if (load) begin
            tx_sr    <= load_data;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            bit_done <= 1'b0;
        end else begin
            if (rise_en) begin
                rx_sr <= {rx_sr[6:0], miso};
            end
            if (fall_en) begin
                tx_sr    <= {tx_sr[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
                bit_done <= (bit_cnt == 3'd7);
            end
        end
    end

    assign mosi    = tx_sr[7];
    assign rx_data = rx_sr;

endmodule

// File: rtl/jstk_spi_master.sv
// rtl/jstk_spi_master.sv - SPI mode-0 transaction engine for the PmodJSTK
// Purpose: on each sndRec rising edge, send DIN and capture 5 joystick bytes into DOUT.
// Ports:
//   CLK     12 MHz system clock
//   RST     asynchronous active-high reset
//   sndRec  transaction request, rising edge starts a frame
//   DIN     command bytes, DIN[39:32] sent first
//   MISO    serial data from the joystick
//   SS      slave select, active low
//   SCLK    serial clock, idles low
//   MOSI    serial data to the joystick, MSB first
//   DOUT    last complete received frame, first byte in [39:32]
//   BUSY    high from start acceptance until SS returns high
//   DONE    one-cycle pulse when DOUT updates
module jstk_spi_master
    import jstk_spi_master_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sndRec,
    input  logic [8*NBYTES-1:0]   DIN,
    input  logic                  MISO,
    output logic                  SS,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic [8*NBYTES-1:0]   DOUT,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int W      = 8 * NBYTES;
    localparam int TICK_W = $clog2(max3(SCLK_HALF, SS_SETUP, BYTE_GAP));
    localparam int BYTE_W = $clog2(NBYTES + 1);

    state_t              state, state_n;
    logic                sndrec_q;
    logic                start;
    logic [TICK_W-1:0]   tick, tick_val;
    logic                tick_ld;
    logic                start_acc, rise_en, fall_en, byte_end, sclk_n;
    logic [BYTE_W-1:0]   byte_cnt;
    logic [W-1:0]        tx_frame, rx_frame;
    logic                sh_load, bit_done;
    logic [7:0]          sh_load_data, rx_byte;

    assign start = sndRec & ~sndrec_q;

    // The shifter holds the byte in flight; tx_frame holds the bytes still to go,
    // so the next byte is loaded at the end of each byte and MOSI settles during GAP.
    assign sh_load      = start_acc | byte_end;
    assign sh_load_data = start_acc ? DIN[W-1 -: 8] : tx_frame[W-1 -: 8];

    jstk_spi_master_shifter u_shifter (
        .clk       (CLK),
        .rst       (RST),
        .load      (sh_load),
        .load_data (sh_load_data),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .miso      (MISO),
        .mosi      (MOSI),
        .rx_data   (rx_byte),
        .bit_done  (bit_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Every timed wait loads tick with (length-1) and advances when it reaches zero,
    // so a wait of N cycles spends exactly N cycles in that state/phase.
    always_comb begin
        state_n   = state;
        tick_ld   = 1'b0;
        tick_val  = '0;
        start_acc = 1'b0;
        rise_en   = 1'b0;
        fall_en   = 1'b0;
        byte_end  = 1'b0;
        sclk_n    = SCLK;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_n   = SETUP;
                    tick_ld   = 1'b1;
                    tick_val  = TICK_W'(SS_SETUP - 1);
                end
            end
            SETUP, GAP: begin
                if (tick == '0) begin
                    state_n  = SHIFT;
                    rise_en  = 1'b1;
                    sclk_n   = 1'b1;
                    tick_ld  = 1'b1;
                    tick_val = TICK_W'(SCLK_HALF - 1);
                end
            end
            SHIFT: begin
                if (tick == '0) begin
                    if (SCLK) begin
                        fall_en  = 1'b1;
                        sclk_n   = 1'b0;
                        tick_ld  = 1'b1;
                        tick_val = TICK_W'(SCLK_HALF - 1);
                    end else if (bit_done) begin
                        // Low half of the 8th bit has elapsed: the byte is complete.
                        byte_end = 1'b1;
                        if (byte_cnt == BYTE_W'(NBYTES - 1)) begin
                            state_n = DONE_ST;
                        end else begin
                            state_n  = GAP;
                            tick_ld  = 1'b1;
                            tick_val = TICK_W'(BYTE_GAP - 1);
                        end
                    end else begin
                        rise_en  = 1'b1;
                        sclk_n   = 1'b1;
                        tick_ld  = 1'b1;
                        tick_val = TICK_W'(SCLK_HALF - 1);
                    end
                end
            end
            DONE_ST: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so SS/SCLK/BUSY never glitch.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sndrec_q <= 1'b0;
            tick     <= '0;
            byte_cnt <= '0;
            tx_frame <= '0;
            rx_frame <= '0;
            SCLK     <= 1'b0;
            SS       <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            DOUT     <= '0;
        end else begin
            sndrec_q <= sndRec;
            if (tick_ld) begin
                tick <= tick_val;
            end else if (tick != '0) begin
                tick <= tick - 1'b1;
            end
            if (start_acc) begin
                byte_cnt <= '0;
                rx_frame <= '0;
                tx_frame <= {DIN[W-9:0], 8'h00};
            end else if (byte_end) begin
                byte_cnt <= byte_cnt + 1'b1;
                rx_frame <= {rx_frame[W-9:0], rx_byte};
                tx_frame <= {tx_frame[W-9:0], 8'h00};
            end
            SCLK <= sclk_n;
            SS   <= (state_n == IDLE);
            BUSY <= (state_n != IDLE);
            DONE <= (state == DONE_ST);
            if (state == DONE_ST) begin
                DOUT <= rx_frame;
            end
        end
    end

endmodule

// File: tb/tb_jstk_spi_master.sv
// tb/tb_jstk_spi_master.sv - directed self-checking bench for jstk_spi_master
module tb_jstk_spi_master;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        sndRec = 1'b0;
    logic [39:0] DIN = '0;
    logic        MISO;
    logic        SS, SCLK, MOSI, BUSY, DONE;
    logic [39:0] DOUT;

    always #5 CLK = ~CLK;

    jstk_spi_master dut (
        .CLK    (CLK),
        .RST    (RST),
        .sndRec (sndRec),
        .DIN    (DIN),
        .MISO   (MISO),
        .SS     (SS),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .DOUT   (DOUT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Slave model and frame monitor, sampled on the inactive clock edge.
    logic        echo = 1'b1;
    logic [7:0]  reply [0:5];
    logic [7:0]  s_tx = '0;
    logic [7:0]  s_rx = '0;
    int          s_cnt = 0;
    int          s_byte = 0;
    logic        ss_d = 1'b1;
    logic        sclk_d = 1'b0;
    int          cyc = 0, rises = 0, done_cnt = 0;
    int          ss_run = 0, ss_len = 0;
    int          t_ss_fall = 0, t_rise_prev = 0, t_fall = 0;
    int          rise_idx = 0, first_dt = 0, period = 0, max_low = 0;
    logic        have_fall = 1'b0;
    logic [39:0] mosi_cap = '0;

    assign MISO = s_tx[7];

    always @(negedge CLK) begin
        cyc    <= cyc + 1;
        ss_d   <= SS;
        sclk_d <= SCLK;
        if (DONE === 1'b1) done_cnt <= done_cnt + 1;
        if (SS === 1'b0) ss_run <= ss_d ? 1 : ss_run + 1;
        if (!ss_d && SS) ss_len <= ss_run;
        if (ss_d && !SS) begin
            s_tx      <= echo ? 8'h00 : reply[0];
            s_cnt     <= 0;
            s_byte    <= 0;
            t_ss_fall <= cyc;
            rise_idx  <= 0;
            have_fall <= 1'b0;
            max_low   <= 0;
        end else if (!sclk_d && SCLK) begin
            rises    <= rises + 1;
            mosi_cap <= {mosi_cap[38:0], MOSI};
            s_rx     <= {s_rx[6:0], MOSI};
            s_cnt    <= s_cnt + 1;
            if (rise_idx == 0) first_dt <= cyc - t_ss_fall;
            if (rise_idx == 1) period <= cyc - t_rise_prev;
            t_rise_prev <= cyc;
            rise_idx    <= rise_idx + 1;
            if (have_fall && (cyc - t_fall) > max_low) max_low <= cyc - t_fall;
        end else if (sclk_d && !SCLK) begin
            t_fall    <= cyc;
            have_fall <= 1'b1;
            if (s_cnt == 8) begin
                s_cnt  <= 0;
                s_byte <= s_byte + 1;
                s_tx   <= echo ? s_rx : reply[s_byte + 1];
            end else begin
                s_tx <= {s_tx[6:0], 1'b0};
            end
        end
    end

    task automatic pulse(input int n);
        sndRec = 1'b1;
        repeat (n) @(negedge CLK);
        sndRec = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int bad, r0, d0;

        for (int i = 0; i < 6; i++) reply[i] = 8'h00;

        // Reset and idle
        repeat (3) @(negedge CLK);
        chk("rst_ss", SS, 1);
        chk("rst_sclk", SCLK, 0);
        chk("rst_mosi", MOSI, 0);
        chk("rst_dout", DOUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        RST = 1'b0;
        bad = 0;
        repeat (10000) begin
            @(negedge CLK);
            if (SS !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0 || DOUT !== 40'h0 ||
                BUSY !== 1'b0 || DONE !== 1'b0) bad++;
        end
        chk("idle_10000", bad, 0);

        // Loopback frame with timing
        echo = 1'b1;
        DIN  = 40'h84FF00AA00;
        r0 = rises; d0 = done_cnt;
        pulse(4);
        wait_done(9000, ok);
        chk("lb_done_seen", ok, 1);
        chk("lb_dout", DOUT, 40'h0084FF00AA);
        repeat (20) @(negedge CLK);
        chk("lb_rises", rises - r0, 40);
        chk("lb_mosi_bits", mosi_cap, 40'h84FF00AA00);
        chk("lb_done_once", done_cnt - d0, 1);
        chk("lb_ss_low", ss_len, 7861);
        chk("tm_ss_to_rise", first_dt, 180);
        chk("tm_sclk_period", period, 180);
        chk("tm_byte_gap", max_low, 210);
        chk("lb_ss_idle", SS, 1);
        chk("lb_busy_idle", BUSY, 0);

        // Start while busy is ignored
        DIN = 40'h8400112233;
        r0 = rises; d0 = done_cnt;
        pulse(3);
        repeat (1000) @(negedge CLK);
        chk("bz_busy_mid", BUSY, 1);
        pulse(3);
        wait_done(9000, ok);
        chk("bz_done_seen", ok, 1);
        chk("bz_dout", DOUT, 40'h0084001122);
        repeat (200) @(negedge CLK);
        chk("bz_done_once", done_cnt - d0, 1);
        chk("bz_rises", rises - r0, 40);
        chk("bz_no_restart", BUSY, 0);

        // Mid-frame reset during byte 3
        DIN = 40'h84DEADBEEF;
        r0 = rises;
        pulse(3);
        ok = 1'b0;
        for (int i = 0; i < 9000 && !ok; i++) begin
            @(negedge CLK);
            if (rises - r0 >= 17) ok = 1'b1;
        end
        chk("mr_reach_byte3", ok, 1);
        chk("mr_sclk_pre", SCLK, 1);
        chk("mr_ss_pre", SS, 0);
        #2 RST = 1'b1;
        #1;
        chk("mr_ss_async", SS, 1);
        chk("mr_sclk_async", SCLK, 0);
        chk("mr_busy_async", BUSY, 0);
        chk("mr_dout_async", DOUT, 0);
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        DIN = 40'h8412345678;
        r0 = rises; d0 = done_cnt;
        pulse(3);
        wait_done(9000, ok);
        chk("mr_done_seen", ok, 1);
        chk("mr_dout_clean", DOUT, 40'h0084123456);
        repeat (20) @(negedge CLK);
        chk("mr_rises", rises - r0, 40);
        chk("mr_done_once", done_cnt - d0, 1);
        chk("mr_mosi_bits", mosi_cap, 40'h8412345678);
        chk("mr_ss_low", ss_len, 7861);

        // Button decode with sndRec held high
        echo = 1'b0;
        reply[0] = 8'h10; reply[1] = 8'h02; reply[2] = 8'hF4;
        reply[3] = 8'h01; reply[4] = 8'h03; reply[5] = 8'h00;
        DIN = 40'h8400000000;
        d0 = done_cnt;
        sndRec = 1'b1;
        wait_done(9000, ok);
        chk("bt_done_seen", ok, 1);
        chk("bt_dout", DOUT, 40'h1002F40103);
        chk("bt_buttons", DOUT[1:0], 2'b11);
        repeat (16000) @(negedge CLK);
        sndRec = 1'b0;
        repeat (20) @(negedge CLK);
        chk("bt_single_frame", done_cnt - d0, 1);
        chk("bt_busy_idle", BUSY, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
